// File: rtl/stack_flit_merge.sv
// stack_flit_merge: per-link flit reassembly into wide packet words, merged
// onto one registered output by a packet-granular round-robin arbiter.
//
// Handshake semantics (all ports): a transfer happens on a rising clk edge
// where valid and ready are both high. A producer holding valid keeps its
// payload stable until the transfer; ready may be asserted independently of
// valid. out_* never change while out_valid is high and out_ready is low.
module stack_flit_merge #(
  parameter int NUM_LINKS = 2,
  parameter int FLIT_W    = 11,
  parameter int MAX_FLITS = 4,
  localparam int P     = FLIT_W - 1,
  localparam int OUT_W = MAX_FLITS * P,
  localparam int CW    = $clog2(MAX_FLITS + 1),
  localparam int LW    = (NUM_LINKS > 1) ? $clog2(NUM_LINKS) : 1,
  localparam int IW    = (MAX_FLITS > 1) ? $clog2(MAX_FLITS) : 1
) (
  input  logic                        clk,
  input  logic                        _reset,
  input  logic [NUM_LINKS*FLIT_W-1:0] in_data,
  input  logic [NUM_LINKS-1:0]        in_valid,
  output logic [NUM_LINKS-1:0]        in_ready,
  output logic [OUT_W-1:0]            out_data,
  output logic [CW-1:0]               out_count,
  output logic [LW-1:0]               out_link,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_LINKS-1:0]        err_overflow,
  input  logic                        err_clear,
  output logic [2*NUM_LINKS-1:0]      dbg_state
);

  // ASSEMBLE collects flits, HOLD waits for the output grant, DISCARD drops
  // the remainder of an over-long sequence up to and including its tail.
  typedef enum logic [1:0] {
    ASSEMBLE = 2'd0,
    HOLD     = 2'd1,
    DISCARD  = 2'd2
  } link_state_t;

  link_state_t            state_q [NUM_LINKS];
  link_state_t            state_d [NUM_LINKS];
  logic [IW-1:0]          idx_q   [NUM_LINKS];
  logic [IW-1:0]          idx_d   [NUM_LINKS];
  logic [OUT_W-1:0]       asm_q   [NUM_LINKS];
  logic [OUT_W-1:0]       asm_d   [NUM_LINKS];
  logic [CW-1:0]          cnt_q   [NUM_LINKS];
  logic [CW-1:0]          cnt_d   [NUM_LINKS];

  logic [NUM_LINKS-1:0]   hold_vec;
  logic [NUM_LINKS-1:0]   accept;
  logic [NUM_LINKS-1:0]   grant_vec;
  logic [NUM_LINKS-1:0]   ovf_set;
  logic [FLIT_W-1:0]      flit;
  logic [LW-1:0]          rr_ptr;
  logic [LW-1:0]          grant_idx;
  logic [LW-1:0]          slot;
  logic                   any_grant;
  logic                   loadable;

  // Link index base+off wrapped into 0..NUM_LINKS-1.
  function automatic logic [LW-1:0] rr_slot(input logic [LW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_LINKS) s = s - NUM_LINKS;
    return LW'(s);
  endfunction

  // Per-link ready, accept strobes and exposed FSM state.
  always_comb begin
    hold_vec  = '0;
    accept    = '0;
    in_ready  = '0;
    dbg_state = '0;
    for (int k = 0; k < NUM_LINKS; k++) begin
      hold_vec[k]          = (state_q[k] == HOLD);
      in_ready[k]          = (state_q[k] != HOLD) & _reset;
      accept[k]            = in_valid[k] & in_ready[k];
      dbg_state[k*2 +: 2]  = state_q[k];
    end
  end

  // Round-robin pick of the first holding link at or after rr_ptr.
  always_comb begin
    loadable  = !out_valid || out_ready;
    any_grant = 1'b0;
    grant_idx = '0;
    grant_vec = '0;
    slot      = '0;
    for (int i = 0; i < NUM_LINKS; i++) begin
      slot = rr_slot(rr_ptr, i);
      if (loadable && !any_grant && hold_vec[slot]) begin
        any_grant       = 1'b1;
        grant_idx       = slot;
        grant_vec[slot] = 1'b1;
      end
    end
  end

  // Link FSM next-state: assembly, overflow detection and resync.
  always_comb begin
    flit    = '0;
    ovf_set = '0;
    for (int k = 0; k < NUM_LINKS; k++) begin
      state_d[k] = state_q[k];
      idx_d[k]   = idx_q[k];
      asm_d[k]   = asm_q[k];
      cnt_d[k]   = cnt_q[k];
      flit       = in_data[k*FLIT_W +: FLIT_W];
      case (state_q[k])
        ASSEMBLE: begin
          if (accept[k]) begin
            asm_d[k][int'(idx_q[k])*P +: P] = flit[P-1:0];
            if (flit[FLIT_W-1]) begin
              cnt_d[k]   = CW'(idx_q[k]) + CW'(1);
              state_d[k] = HOLD;
            end else if (idx_q[k] == IW'(MAX_FLITS - 1)) begin
              // Too many flits: drop what we have and wait for the tail.
              asm_d[k]   = '0;
              idx_d[k]   = '0;
              ovf_set[k] = 1'b1;
              state_d[k] = DISCARD;
            end else begin
              idx_d[k] = idx_q[k] + IW'(1);
            end
          end
        end
        HOLD: begin
          if (grant_vec[k]) begin
            state_d[k] = ASSEMBLE;
            idx_d[k]   = '0;
            asm_d[k]   = '0;
          end
        end
        DISCARD: begin
          if (accept[k] && flit[FLIT_W-1]) begin
            state_d[k] = ASSEMBLE;
            idx_d[k]   = '0;
          end
        end
        default: begin
          state_d[k] = ASSEMBLE;
          idx_d[k]   = '0;
          asm_d[k]   = '0;
        end
      endcase
    end
  end

  // Link FSM state, index, buffer and count registers.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      for (int k = 0; k < NUM_LINKS; k++) begin
        state_q[k] <= ASSEMBLE;
        idx_q[k]   <= '0;
        asm_q[k]   <= '0;
        cnt_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_LINKS; k++) begin
        state_q[k] <= state_d[k];
        idx_q[k]   <= idx_d[k];
        asm_q[k]   <= asm_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
    end
  end

  // Sticky overflow flags; a new overflow wins over a same-cycle clear.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      err_overflow <= '0;
    end else begin
      err_overflow <= ovf_set | (err_overflow & ~{NUM_LINKS{err_clear}});
    end
  end

  // Output register: reload on grant, drop valid when drained with nothing held.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_link  <= '0;
      rr_ptr    <= '0;
    end else if (loadable) begin
      if (any_grant) begin
        out_valid <= 1'b1;
        out_data  <= asm_q[grant_idx];
        out_count <= cnt_q[grant_idx];
        out_link  <= grant_idx;
        rr_ptr    <= rr_slot(grant_idx, 1);
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stack_flit_merge.sv
// Testbench for stack_flit_merge: directed scenarios plus randomized traffic
// checked against a flit-sequence reference model.
module tb_stack_flit_merge;

  localparam int NL    = 2;
  localparam int FW    = 11;
  localparam int MF    = 4;
  localparam int P     = FW - 1;
  localparam int OW    = MF * P;
  localparam int EXP_W = 3 + OW;

  logic              clk;
  logic              rst_n;
  logic [NL*FW-1:0]  in_data;
  logic [NL-1:0]     in_valid;
  logic [NL-1:0]     in_ready;
  logic [OW-1:0]     out_data;
  logic [2:0]        out_count;
  logic [0:0]        out_link;
  logic              out_valid;
  logic              out_ready;
  logic [NL-1:0]     err_overflow;
  logic              err_clear;
  logic [2*NL-1:0]   dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Per-link flit queues fed to the driver, and captured output transfers.
  logic [FW-1:0]     lk_q [NL][$];
  logic [OW-1:0]     cap_data[$];
  logic [2:0]        cap_cnt[$];
  logic [0:0]        cap_link[$];
  int                cap_cyc[$];

  // Reference model: expected packets per link and overflow flags.
  logic [EXP_W-1:0]  exp_q [NL][$];
  logic [NL-1:0]     exp_ovf;
  logic [OW-1:0]     m_data [NL];
  int                m_n    [NL];
  logic              m_disc [NL];

  stack_flit_merge #(.NUM_LINKS(NL), .FLIT_W(FW), .MAX_FLITS(MF)) dut (
    .clk(clk), ._reset(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_count(out_count),
    .out_link(out_link), .out_valid(out_valid), .out_ready(out_ready),
    .err_overflow(err_overflow), .err_clear(err_clear), .dbg_state(dbg_state)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    tick();
    rst_n    = 1'b0;
    in_valid = '0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // Driver: streams lk_q on all links, records output transfers.
  // mode 0: out_ready low; 1: high; 2: random while flits remain.
  task automatic run_links(input int mode, input string name);
    int drain = 0;
    int used  = 0;
    bit busy;
    cap_data.delete(); cap_cnt.delete(); cap_link.delete(); cap_cyc.delete();
    while (drain < 8) begin
      if (used >= 3000) begin
        n_tests++; n_fail++;
        $display("FAIL %s: timeout, pending link flits %0d/%0d, required 0", name, lk_q[0].size(), lk_q[1].size());
        break;
      end
      tick();
      busy = 1'b0;
      for (int k = 0; k < NL; k++) begin
        if (lk_q[k].size() > 0) begin
          in_valid[k]          = 1'b1;
          in_data[k*FW +: FW]  = lk_q[k][0];
          busy                 = 1'b1;
        end else begin
          in_valid[k] = 1'b0;
        end
      end
      if (mode == 0) out_ready = 1'b0;
      else if (mode == 1 || !busy) out_ready = 1'b1;
      else out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      for (int k = 0; k < NL; k++)
        if (in_valid[k] && in_ready[k]) void'(lk_q[k].pop_front());
      if (out_valid && out_ready) begin
        cap_data.push_back(out_data); cap_cnt.push_back(out_count);
        cap_link.push_back(out_link); cap_cyc.push_back(cyc);
      end
      if (!busy) drain++;
      used++;
    end
  endtask

  // Model of one link: tail ends a packet, MAX_FLITS non-tail flits overflow.
  task automatic model_feed(input int k, input logic [FW-1:0] f);
    if (m_disc[k]) begin
      if (f[FW-1]) m_disc[k] = 1'b0;
    end else begin
      m_data[k] = m_data[k] | ({{(OW-P){1'b0}}, f[P-1:0]} << (P * m_n[k]));
      m_n[k]++;
      if (f[FW-1]) begin
        exp_q[k].push_back({3'(m_n[k]), m_data[k]});
        m_n[k] = 0; m_data[k] = '0;
      end else if (m_n[k] == MF) begin
        m_n[k] = 0; m_data[k] = '0; m_disc[k] = 1'b1; exp_ovf[k] = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", out_data); end
    n_tests++; if (out_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", out_count); end
    n_tests++; if (out_link !== 1'b0) begin n_fail++; $display("FAIL reset_link: got %0d want 0", out_link); end
    n_tests++; if (err_overflow !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b want 00", err_overflow); end
    n_tests++; if (in_ready !== 2'b00) begin n_fail++; $display("FAIL reset_in_ready: got %b want 00", in_ready); end
    n_tests++; if (dbg_state !== '0) begin n_fail++; $display("FAIL reset_state: got %h want 0", dbg_state); end
    rst_n = 1'b1;
    #1;
    n_tests++; if (in_ready !== 2'b11) begin n_fail++; $display("FAIL release_in_ready: got %b want 11", in_ready); end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    in_valid  = 2'b10;
    in_data[FW +: FW] = 11'b10111111100;
    tick();
    in_valid = '0;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %0b want 0", out_valid); end
    n_tests++; if (in_ready[1] !== 1'b0) begin n_fail++; $display("FAIL single_hold_ready: got %0b want 0", in_ready[1]); end
    tick();
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0b want 1", out_valid); end
    n_tests++; if (out_data !== 40'h00000001FC) begin n_fail++; $display("FAIL single_data: got %h want 00000001fc", out_data); end
    n_tests++; if (out_count !== 3'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", out_count); end
    n_tests++; if (out_link !== 1'b1) begin n_fail++; $display("FAIL single_link: got %0d want 1", out_link); end
    n_tests++; if (in_ready[1] !== 1'b1) begin n_fail++; $display("FAIL single_ready_back: got %0b want 1", in_ready[1]); end
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_one_cycle: got %0b want 0", out_valid); end
  endtask

  task automatic test_multi_flit();
    lk_q[0].push_back(11'h155); lk_q[0].push_back(11'h2AA); lk_q[0].push_back(11'h7FF);
    run_links(1, "multi_flit");
    n_tests++; if (cap_data.size() != 1) begin n_fail++; $display("FAIL multi_npkt: got %0d want 1", cap_data.size()); end
    if (cap_data.size() == 1) begin
      n_tests++; if (cap_data[0] !== 40'h003FFAA955) begin n_fail++; $display("FAIL multi_data: got %h want 003ffaa955", cap_data[0]); end
      n_tests++; if (cap_cnt[0] !== 3'd3) begin n_fail++; $display("FAIL multi_count: got %0d want 3", cap_cnt[0]); end
      n_tests++; if (cap_link[0] !== 1'b0) begin n_fail++; $display("FAIL multi_link: got %0d want 0", cap_link[0]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [OW-1:0] want;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      lk_q[0].push_back(11'h410 + 11'(i));
      lk_q[1].push_back(11'h420 + 11'(i));
    end
    run_links(1, "back_to_back");
    n_tests++; if (cap_data.size() != 8) begin n_fail++; $display("FAIL b2b_npkt: got %0d want 8", cap_data.size()); end
    for (int i = 0; i < 8 && i < cap_data.size(); i++) begin
      want = OW'((i % 2 == 1) ? 32'h20 : 32'h10) + OW'(i / 2);
      n_tests++; if (cap_link[i] !== 1'(i % 2)) begin n_fail++; $display("FAIL b2b_order[%0d]: got link %0d want %0d", i, cap_link[i], i % 2); end
      n_tests++; if (cap_data[i] !== want) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", i, cap_data[i], want); end
      n_tests++; if (cap_cyc[i] != cap_cyc[0] + i) begin n_fail++; $display("FAIL b2b_gap[%0d]: got cycle %0d want %0d", i, cap_cyc[i], cap_cyc[0] + i); end
    end
  endtask

  task automatic test_overflow();
    lk_q[0].push_back(11'h001); lk_q[0].push_back(11'h002); lk_q[0].push_back(11'h003);
    run_links(1, "ovf_pre");
    n_tests++; if (err_overflow !== 2'b00) begin n_fail++; $display("FAIL ovf_before: got %b want 00", err_overflow); end
    lk_q[0].push_back(11'h004);
    run_links(1, "ovf_fourth");
    n_tests++; if (err_overflow !== 2'b01) begin n_fail++; $display("FAIL ovf_set: got %b want 01", err_overflow); end
    n_tests++; if (cap_data.size() != 0) begin n_fail++; $display("FAIL ovf_no_out: got %0d pkts want 0", cap_data.size()); end
    lk_q[0].push_back(11'h005); lk_q[0].push_back(11'h406);
    lk_q[0].push_back(11'h001); lk_q[0].push_back(11'h402);
    run_links(1, "ovf_resync");
    n_tests++; if (cap_data.size() != 1) begin n_fail++; $display("FAIL ovf_resync_npkt: got %0d want 1", cap_data.size()); end
    if (cap_data.size() == 1) begin
      n_tests++; if (cap_data[0] !== 40'h0000000801) begin n_fail++; $display("FAIL ovf_resync_data: got %h want 0000000801", cap_data[0]); end
      n_tests++; if (cap_cnt[0] !== 3'd2) begin n_fail++; $display("FAIL ovf_resync_count: got %0d want 2", cap_cnt[0]); end
    end
    n_tests++; if (err_overflow !== 2'b01) begin n_fail++; $display("FAIL ovf_sticky: got %b want 01", err_overflow); end
    tick(); err_clear = 1'b1;
    tick(); err_clear = 1'b0;
    n_tests++; if (err_overflow !== 2'b00) begin n_fail++; $display("FAIL ovf_clear: got %b want 00", err_overflow); end
  endtask

  task automatic test_stall();
    lk_q[0].push_back(11'h401); lk_q[0].push_back(11'h402);
    run_links(0, "stall");
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid: got %0b want 1", out_valid); end
    n_tests++; if (out_data !== 40'h1) begin n_fail++; $display("FAIL stall_data: got %h want 1", out_data); end
    n_tests++; if (in_ready[0] !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %0b want 0", in_ready[0]); end
    repeat (3) tick();
    n_tests++; if (out_data !== 40'h1 || out_link !== 1'b0) begin n_fail++; $display("FAIL stall_stable: got %h/%0d want 1/0", out_data, out_link); end
    out_ready = 1'b1;
    tick();
    n_tests++; if (out_valid !== 1'b1 || out_data !== 40'h2) begin n_fail++; $display("FAIL stall_reload: got %0b/%h want 1/2", out_valid, out_data); end
    n_tests++; if (in_ready[0] !== 1'b1) begin n_fail++; $display("FAIL stall_ready_back: got %0b want 1", in_ready[0]); end
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drain: got %0b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    lk_q[0].push_back(11'h455);
    lk_q[1].push_back(11'h0AB); lk_q[1].push_back(11'h0CD);
    run_links(0, "reset_mid");
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pending: got %0b want 1", out_valid); end
    tick();
    rst_n = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0 || out_data !== '0) begin n_fail++; $display("FAIL rmid_out: got %0b/%h want 0/0", out_valid, out_data); end
    n_tests++; if (out_count !== 3'd0 || out_link !== 1'b0) begin n_fail++; $display("FAIL rmid_meta: got %0d/%0d want 0/0", out_count, out_link); end
    n_tests++; if (in_ready !== 2'b00) begin n_fail++; $display("FAIL rmid_in_ready: got %b want 00", in_ready); end
    repeat (2) tick();
    rst_n = 1'b1;
    lk_q[1].push_back(11'h400);
    run_links(1, "reset_after");
    n_tests++; if (cap_data.size() != 1) begin n_fail++; $display("FAIL rmid_npkt: got %0d want 1", cap_data.size()); end
    if (cap_data.size() == 1) begin
      n_tests++; if (cap_data[0] !== '0) begin n_fail++; $display("FAIL rmid_stale: got %h want 0", cap_data[0]); end
      n_tests++; if (cap_cnt[0] !== 3'd1 || cap_link[0] !== 1'b1) begin n_fail++; $display("FAIL rmid_meta2: got %0d/%0d want 1/1", cap_cnt[0], cap_link[0]); end
    end
  endtask

  task automatic test_random();
    logic [FW-1:0]    f;
    logic [EXP_W-1:0] e;
    int               len;
    apply_reset();
    exp_ovf = '0;
    for (int k = 0; k < NL; k++) begin
      exp_q[k].delete(); m_n[k] = 0; m_data[k] = '0; m_disc[k] = 1'b0;
      for (int p = 0; p < 12; p++) begin
        len = $urandom_range(1, 6);
        for (int j = 0; j < len; j++) begin
          f = {(j == len - 1), 10'($urandom_range(0, 1023))};
          lk_q[k].push_back(f);
          model_feed(k, f);
        end
      end
    end
    run_links(2, "random");
    for (int i = 0; i < cap_data.size(); i++) begin
      n_tests++;
      if (exp_q[cap_link[i]].size() == 0) begin
        n_fail++; $display("FAIL rand_extra[%0d]: got link %0d pkt %h, want none", i, cap_link[i], cap_data[i]);
      end else begin
        e = exp_q[cap_link[i]].pop_front();
        if ({cap_cnt[i], cap_data[i]} !== e) begin
          n_fail++; $display("FAIL rand_pkt[%0d] link %0d: got %0d/%h want %0d/%h", i, cap_link[i], cap_cnt[i], cap_data[i], e[EXP_W-1 -: 3], e[OW-1:0]);
        end
      end
    end
    for (int k = 0; k < NL; k++) begin
      n_tests++; if (exp_q[k].size() != 0) begin n_fail++; $display("FAIL rand_missing link %0d: got %0d left want 0", k, exp_q[k].size()); end
    end
    n_tests++; if (err_overflow !== exp_ovf) begin n_fail++; $display("FAIL rand_err: got %b want %b", err_overflow, exp_ovf); end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    err_clear = 1'b0;
    test_reset();
    test_single();
    test_multi_flit();
    test_back_to_back();
    test_overflow();
    test_stall();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
